// File: rtl/reg_bus_master_if.sv
// Command/response byte streams plus the clk_usb register bus, as seen by the
// register bus initiator (master) and by the host and responders (slave).
interface reg_bus_master_if #(
  parameter int pBYTECNT_SIZE = 7
);
  logic [7:0]               cmd_data;
  logic                     cmd_valid;
  logic                     cmd_ready;
  logic [7:0]               rsp_data;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [7:0]               reg_address;
  logic [pBYTECNT_SIZE-1:0] reg_bytecnt;
  logic [7:0]               reg_datai;
  logic                     reg_read;
  logic                     reg_write;
  logic [7:0]               reg_datao;

  modport master (
    input  cmd_data, cmd_valid, rsp_ready, reg_datao,
    output cmd_ready, rsp_data, rsp_valid,
    output reg_address, reg_bytecnt, reg_datai, reg_read, reg_write
  );

  modport slave (
    output cmd_data, cmd_valid, rsp_ready, reg_datao,
    input  cmd_ready, rsp_data, rsp_valid,
    input  reg_address, reg_bytecnt, reg_datai, reg_read, reg_write
  );
endinterface

// File: rtl/reg_bus_master.sv
// Register bus initiator: decodes OPCODE/ADDR/LEN(/data) command frames into
// reg_read/reg_write bursts and streams read data or a status byte back.
module reg_bus_master #(
  parameter int pBYTECNT_SIZE = 7,
  parameter int pREAD_LATENCY = 1
) (
  input  logic              clk_usb,
  input  logic              reset_n,
  reg_bus_master_if.master  bus,
  output logic              busy
);
  localparam int MAXB = 1 << pBYTECNT_SIZE;

  typedef enum logic [3:0] {
    IDLE, ADDR, LEN, WDATA, WSTROBE, RSTROBE, RWAIT, RSEND, STATUS
  } state_t;

  state_t                   state, state_nx;
  logic                     is_read, is_read_nx;
  logic [7:0]               addr_nx, datai_nx, rsp_data_nx;
  logic [pBYTECNT_SIZE-1:0] bcnt_nx, last, last_nx;
  logic [1:0]               wait_cnt, wait_cnt_nx;
  logic                     accept, len_bad, at_last;

  // Gating with reset_n keeps the host from handing over a byte while held in reset.
  assign bus.cmd_ready = reset_n & (state inside {IDLE, ADDR, LEN, WDATA});
  assign accept        = bus.cmd_valid & bus.cmd_ready;
  assign len_bad       = (bus.cmd_data == 8'd0) || (int'({24'd0, bus.cmd_data}) > MAXB);
  assign at_last       = (bus.reg_bytecnt == last);
  assign busy          = (state != IDLE);

  always_ff @(posedge clk_usb or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      is_read         <= 1'b0;
      bus.reg_address <= '0;
      bus.reg_bytecnt <= '0;
      bus.reg_datai   <= '0;
      bus.rsp_data    <= '0;
      last            <= '0;
      wait_cnt        <= '0;
    end else begin
      state           <= state_nx;
      is_read         <= is_read_nx;
      bus.reg_address <= addr_nx;
      bus.reg_bytecnt <= bcnt_nx;
      bus.reg_datai   <= datai_nx;
      bus.rsp_data    <= rsp_data_nx;
      last            <= last_nx;
      wait_cnt        <= wait_cnt_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    is_read_nx    = is_read;
    addr_nx       = bus.reg_address;
    bcnt_nx       = bus.reg_bytecnt;
    datai_nx      = bus.reg_datai;
    rsp_data_nx   = bus.rsp_data;
    last_nx       = last;
    wait_cnt_nx   = wait_cnt;
    bus.rsp_valid = 1'b0;
    bus.reg_read  = 1'b0;
    bus.reg_write = 1'b0;
    unique case (state)
      IDLE: if (accept) begin
        if (bus.cmd_data == 8'h00 || bus.cmd_data == 8'h01) begin
          is_read_nx = bus.cmd_data[0];
          state_nx   = ADDR;
        end else begin
          rsp_data_nx = 8'hE1;
          state_nx    = STATUS;
        end
      end
      ADDR: if (accept) begin
        addr_nx  = bus.cmd_data;
        state_nx = LEN;
      end
      LEN: if (accept) begin
        bcnt_nx = '0;
        if (len_bad) begin
          rsp_data_nx = 8'hE2;
          state_nx    = STATUS;
        end else begin
          // Store the index of the final byte so the burst end is a plain compare.
          last_nx  = pBYTECNT_SIZE'(bus.cmd_data - 8'd1);
          state_nx = is_read ? RSTROBE : WDATA;
        end
      end
      WDATA: if (accept) begin
        datai_nx = bus.cmd_data;
        state_nx = WSTROBE;
      end
      WSTROBE: begin
        bus.reg_write = 1'b1;
        if (at_last) begin
          rsp_data_nx = 8'h00;
          state_nx    = STATUS;
        end else begin
          bcnt_nx  = bus.reg_bytecnt + 1'b1;
          state_nx = WDATA;
        end
      end
      RSTROBE: begin
        bus.reg_read = 1'b1;
        wait_cnt_nx  = 2'd1;
        state_nx     = RWAIT;
      end
      // Stay pREAD_LATENCY cycles; the last of them is the one reg_datao is valid in.
      RWAIT: begin
        if (wait_cnt == 2'(pREAD_LATENCY)) begin
          rsp_data_nx = bus.reg_datao;
          state_nx    = RSEND;
        end else begin
          wait_cnt_nx = wait_cnt + 2'd1;
        end
      end
      RSEND: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) begin
          if (at_last) begin
            state_nx = IDLE;
          end else begin
            bcnt_nx  = bus.reg_bytecnt + 1'b1;
            state_nx = RSTROBE;
          end
        end
      end
      STATUS: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end
endmodule

// File: tb/tb_reg_bus_master.sv
// Randomized frame-level bench for reg_bus_master: two instances (read latency 1
// and 3) checked against a frame-level model of bus accesses and response bytes.
module tb_reg_bus_master;
  localparam int MAXB = 128;

  typedef struct {
    logic       w;
    logic [7:0] a;
    int         b;
    logic [7:0] d;
  } acc_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] cmd_data = 8'h00;
  logic       cmd_valid = 1'b0;
  logic       rsp_ready = 1'b0;
  logic       hold_low = 1'b0;
  logic       sel3 = 1'b0;
  logic       busy1, busy3;
  int         gapmax = 0;
  int         n_chk = 0, n_fail = 0;
  acc_t       acc_q[$];
  logic [7:0] rsp_q[$];
  logic [7:0] wdq[$];

  always #5 clk = ~clk;

  reg_bus_master_if #(.pBYTECNT_SIZE(7)) b1();
  reg_bus_master_if #(.pBYTECNT_SIZE(7)) b3();

  reg_bus_master #(.pBYTECNT_SIZE(7), .pREAD_LATENCY(1)) dut1 (
    .clk_usb(clk), .reset_n(reset_n), .bus(b1.master), .busy(busy1));
  reg_bus_master #(.pBYTECNT_SIZE(7), .pREAD_LATENCY(3)) dut3 (
    .clk_usb(clk), .reset_n(reset_n), .bus(b3.master), .busy(busy3));

  assign b1.cmd_data  = cmd_data;
  assign b3.cmd_data  = cmd_data;
  assign b1.cmd_valid = cmd_valid & ~sel3;
  assign b3.cmd_valid = cmd_valid & sel3;
  assign b1.rsp_ready = rsp_ready;
  assign b3.rsp_ready = rsp_ready;

  function automatic logic [7:0] resp_val(input logic [7:0] a, input int b);
    if (a == 8'h0C && b == 0) return 8'hAB;
    if (a == 8'h0C && b == 1) return 8'hCD;
    return (a * 8'd37) ^ 8'(b * 91) ^ 8'h5A;
  endfunction

  // Responders: data appears exactly L cycles after the strobe, zero otherwise.
  logic [7:0] p1;
  logic [7:0] p3a, p3b, p3c;
  always @(posedge clk) begin
    p1  <= b1.reg_read ? resp_val(b1.reg_address, int'(b1.reg_bytecnt)) : 8'h00;
    p3a <= b3.reg_read ? resp_val(b3.reg_address, int'(b3.reg_bytecnt)) : 8'h00;
    p3b <= p3a;
    p3c <= p3b;
  end
  assign b1.reg_datao = p1;
  assign b3.reg_datao = p3c;

  logic       o_cmd_ready, o_rsp_valid, o_reg_read, o_reg_write, o_busy;
  logic [7:0] o_rsp_data, o_reg_address, o_reg_datai;
  logic [6:0] o_reg_bytecnt;
  assign o_cmd_ready   = sel3 ? b3.cmd_ready   : b1.cmd_ready;
  assign o_rsp_valid   = sel3 ? b3.rsp_valid   : b1.rsp_valid;
  assign o_rsp_data    = sel3 ? b3.rsp_data    : b1.rsp_data;
  assign o_reg_read    = sel3 ? b3.reg_read    : b1.reg_read;
  assign o_reg_write   = sel3 ? b3.reg_write   : b1.reg_write;
  assign o_reg_address = sel3 ? b3.reg_address : b1.reg_address;
  assign o_reg_bytecnt = sel3 ? b3.reg_bytecnt : b1.reg_bytecnt;
  assign o_reg_datai   = sel3 ? b3.reg_datai   : b1.reg_datai;
  assign o_busy        = sel3 ? busy3 : busy1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) begin
    #2;
    rsp_ready = hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  always @(negedge clk) if (reset_n) begin
    if (o_reg_write | o_reg_read) begin
      check("strobe_excl", 32'(o_reg_write & o_reg_read), 32'd0);
      acc_q.push_back('{o_reg_write, o_reg_address, int'(o_reg_bytecnt),
                        o_reg_write ? o_reg_datai : 8'h00});
    end
    if (o_rsp_valid && rsp_ready) rsp_q.push_back(o_rsp_data);
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    repeat ($urandom_range(0, gapmax)) @(negedge clk);
    cmd_data  = b;
    cmd_valid = 1'b1;
    while (!o_cmd_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) check("cmd_timeout", 32'd1, 32'd0);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic finish_frame(input acc_t ea[$], input logic [7:0] er[$]);
    int n = 0;
    while ((rsp_q.size() < er.size() || o_busy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) check("frame_timeout", 32'd1, 32'd0);
    repeat (3) @(negedge clk);
    check("n_acc", acc_q.size(), ea.size());
    check("n_rsp", rsp_q.size(), er.size());
    for (int i = 0; i < ea.size() && i < acc_q.size(); i++) begin
      check("acc_w",    32'(acc_q[i].w), 32'(ea[i].w));
      check("acc_addr", 32'(acc_q[i].a), 32'(ea[i].a));
      check("acc_bcnt", acc_q[i].b,      ea[i].b);
      check("acc_data", 32'(acc_q[i].d), 32'(ea[i].d));
    end
    for (int i = 0; i < er.size() && i < rsp_q.size(); i++)
      check("rsp_byte", 32'(rsp_q[i]), 32'(er[i]));
    check("idle_busy", 32'(o_busy), 32'd0);
  endtask

  task automatic run_frame(input logic [7:0] op, input logic [7:0] addr,
                           input logic [7:0] len, input logic [7:0] wd[$]);
    acc_t       ea[$];
    logic [7:0] er[$];
    logic [7:0] bytes[$];
    acc_q.delete();
    rsp_q.delete();
    bytes.push_back(op);
    if (op > 8'h01) er.push_back(8'hE1);
    else begin
      bytes.push_back(addr);
      bytes.push_back(len);
      if (len == 8'd0 || int'(len) > MAXB) er.push_back(8'hE2);
      else if (op == 8'h00) begin
        for (int i = 0; i < int'(len); i++) begin
          bytes.push_back(wd[i]);
          ea.push_back('{1'b1, addr, i, wd[i]});
        end
        er.push_back(8'h00);
      end else begin
        for (int i = 0; i < int'(len); i++) begin
          ea.push_back('{1'b0, addr, i, 8'h00});
          er.push_back(resp_val(addr, i));
        end
      end
    end
    foreach (bytes[i]) send_byte(bytes[i]);
    finish_frame(ea, er);
  endtask

  initial begin
    acc_t       ea[$];
    logic [7:0] er[$];
    logic [7:0] op, len;
    int         n, r;

    #12;
    check("rst_cmd_ready", 32'(o_cmd_ready),   32'd0);
    check("rst_rsp_valid", 32'(o_rsp_valid),   32'd0);
    check("rst_rsp_data",  32'(o_rsp_data),    32'd0);
    check("rst_strobes",   32'({o_reg_read, o_reg_write}), 32'd0);
    check("rst_addr",      32'(o_reg_address), 32'd0);
    check("rst_bcnt",      32'(o_reg_bytecnt), 32'd0);
    check("rst_datai",     32'(o_reg_datai),   32'd0);
    check("rst_busy",      32'(o_busy),        32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Directed: burst write, burst read, bad opcode, bad lengths, max burst.
    wdq = '{8'h11, 8'h22, 8'h33, 8'h44};
    run_frame(8'h00, 8'h05, 8'd4, wdq);
    wdq.delete();
    run_frame(8'h01, 8'h0C, 8'd2, wdq);
    run_frame(8'h7F, 8'h00, 8'd0, wdq);
    run_frame(8'h01, 8'h00, 8'd1, wdq);
    run_frame(8'h00, 8'h33, 8'd0, wdq);
    run_frame(8'h01, 8'h33, 8'd129, wdq);
    run_frame(8'h01, 8'h44, 8'd128, wdq);

    // Response back-pressure: one read strobe only until the host takes the byte.
    acc_q.delete();
    rsp_q.delete();
    hold_low = 1'b1;
    send_byte(8'h01);
    send_byte(8'h3A);
    send_byte(8'd3);
    n = 0;
    while (!o_rsp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (20) @(negedge clk);
    check("stall_reads", acc_q.size(), 1);
    check("stall_rsp",   rsp_q.size(), 0);
    check("stall_valid", 32'(o_rsp_valid), 32'd1);
    check("stall_data",  32'(o_rsp_data), 32'(resp_val(8'h3A, 0)));
    hold_low = 1'b0;
    ea.delete();
    er.delete();
    for (int i = 0; i < 3; i++) begin
      ea.push_back('{1'b0, 8'h3A, i, 8'h00});
      er.push_back(resp_val(8'h3A, i));
    end
    finish_frame(ea, er);

    // Reset while the second write byte is being strobed.
    acc_q.delete();
    rsp_q.delete();
    send_byte(8'h00);
    send_byte(8'h20);
    send_byte(8'd4);
    send_byte(8'hA1);
    send_byte(8'hA2);
    check("mid_wr_strobe", 32'(o_reg_write),   32'd1);
    check("mid_wr_bcnt",   32'(o_reg_bytecnt), 32'd1);
    #1 reset_n = 1'b0;
    #1;
    check("mid_rst_write", 32'(o_reg_write), 32'd0);
    check("mid_rst_busy",  32'(o_busy),      32'd0);
    check("mid_rst_ready", 32'(o_cmd_ready), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    rsp_q.delete();
    repeat (5) @(negedge clk);
    check("mid_rst_norsp", rsp_q.size(), 0);
    wdq = '{8'h5C, 8'hC5};
    run_frame(8'h00, 8'h21, 8'd2, wdq);

    // Random frames with cmd_valid gaps on both latency variants.
    gapmax = 3;
    for (int k = 0; k < 40; k++) begin
      sel3 = (k >= 20);
      r    = $urandom_range(0, 9);
      if (r < 4)       op = 8'h00;
      else if (r < 8)  op = 8'h01;
      else if (r == 8) op = 8'($urandom_range(2, 255));
      else             op = 8'($urandom_range(0, 1));
      if (r == 9) len = $urandom_range(0, 1) ? 8'd0 : 8'($urandom_range(129, 255));
      else        len = 8'($urandom_range(1, 8));
      wdq.delete();
      for (int i = 0; i < int'(len); i++) wdq.push_back(8'($urandom));
      run_frame(op, 8'($urandom), len, wdq);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
